// File: rtl/acc_alu_seq.sv
// Handshaked accumulator ALU: 15-op encoding, Ready/Busy/Error sequencing,
// multi-cycle restoring divider returning {remainder, quotient}, registered flags.
//
// state    | meaning
// ST_READY | accepting ops; single-cycle ops complete on the accept edge
// ST_BUSY  | divider iterating one quotient bit per clock, op_ready low
// ST_ERROR | err high; only CLEAR completes, every other op is discarded
module acc_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [3:0]           op,
   input  logic                 a_sel,
   input  logic [1:0]           b_sel,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic [2*WIDTH-1:0]   acc_val,
   output logic                 done,
   output logic                 busy,
   output logic                 err,
   output logic                 zero,
   output logic                 carry
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_NOT   = 4'd7;
   localparam logic [3:0] OP_NAND  = 4'd8;
   localparam logic [3:0] OP_NOR   = 4'd9;
   localparam logic [3:0] OP_XNOR  = 4'd10;
   localparam logic [3:0] OP_SHL   = 4'd11;
   localparam logic [3:0] OP_SHR   = 4'd12;
   localparam logic [3:0] OP_NOP   = 4'd13;
   localparam logic [3:0] OP_CLEAR = 4'd14;

   typedef enum logic [1:0] {
      ST_READY,
      ST_BUSY,
      ST_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;

   logic                 accept;
   logic [WIDTH-1:0]     a_op, b_op;
   logic [2*WIDTH-1:0]   a_ext, b_ext;
   logic [2*WIDTH-1:0]   res;
   logic                 err_op;
   logic [WIDTH:0]       rem_sh, trial;

   assign op_ready = (state_q != ST_BUSY);
   assign accept   = op_valid && op_ready;
   assign acc_val  = acc_q;
   assign done     = done_q;
   assign busy     = (state_q == ST_BUSY);
   assign err      = (state_q == ST_ERROR);
   assign zero     = zero_q;
   assign carry    = carry_q;

   always_comb begin
      a_op = a_sel ? acc_q[WIDTH-1:0] : a_in;
      case (b_sel)
         2'd0:    b_op = '0;
         2'd1:    b_op = b_in;
         2'd2:    b_op = acc_q[WIDTH-1:0];
         default: b_op = b_q;
      endcase
      a_ext = {{WIDTH{1'b0}}, a_op};
      b_ext = {{WIDTH{1'b0}}, b_op};
   end

   // Shifts by >= 2*WIDTH fall out as zero from the language shift semantics.
   always_comb begin
      res    = '0;
      err_op = 1'b0;
      case (op)
         OP_ADD:   res = a_ext + b_ext;
         OP_SUB: begin
            res    = a_ext - b_ext;
            err_op = (b_op > a_op);
         end
         OP_MUL:   res = a_ext * b_ext;
         OP_DIV:   err_op = (b_op == '0);
         OP_AND:   res = a_ext & b_ext;
         OP_OR:    res = a_ext | b_ext;
         OP_XOR:   res = a_ext ^ b_ext;
         OP_NOT:   res = {{WIDTH{1'b0}}, ~b_op};
         OP_NAND:  res = {{WIDTH{1'b0}}, ~(a_op & b_op)};
         OP_NOR:   res = {{WIDTH{1'b0}}, ~(a_op | b_op)};
         OP_XNOR:  res = {{WIDTH{1'b0}}, ~(a_op ^ b_op)};
         OP_SHL:   res = b_ext << a_op;
         OP_SHR:   res = b_ext >> a_op;
         OP_NOP:   res = acc_q;
         OP_CLEAR: res = '0;
         default:  err_op = 1'b1;
      endcase
   end

   // a_q doubles as the dividend/quotient shift register while dividing.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      zero_d  = zero_q;
      carry_d = carry_q;
      rem_sh  = {rem_q, a_q[WIDTH-1]};
      trial   = rem_sh - {1'b0, b_q};

      case (state_q)
         ST_READY: begin
            if (accept) begin
               a_d = a_op;
               b_d = b_op;
               if (err_op) begin
                  state_d = ST_ERROR;
               end else if (op == OP_DIV) begin
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = ST_BUSY;
               end else begin
                  acc_d   = res;
                  zero_d  = (res == '0);
                  carry_d = (op == OP_ADD) && res[WIDTH];
                  done_d  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               acc_d   = {rem_d, a_d};
               zero_d  = ({rem_d, a_d} == '0);
               carry_d = 1'b0;
               done_d  = 1'b1;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ERROR: begin
            if (accept) begin
               a_d = a_op;
               b_d = b_op;
               if (op == OP_CLEAR) begin
                  acc_d   = '0;
                  zero_d  = 1'b1;
                  carry_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_READY;
               end
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_READY;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq (WIDTH=16) with hand-computed expected values.
module tb_acc_alu_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [3:0]  op = 4'd13;
   logic        a_sel = 1'b0;
   logic [1:0]  b_sel = 2'd0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic [31:0] acc_val;
   logic        done, busy, err, zero, carry;

   int n_checks = 0;
   int n_pass   = 0;
   int n_busy, n_rdy_lo;

   acc_alu_seq #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .a_sel(a_sel), .b_sel(b_sel), .a_in(a_in), .b_in(b_in),
      .acc_val(acc_val), .done(done), .busy(busy), .err(err),
      .zero(zero), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Presents one op for exactly one rising edge; returns 1 ns after that edge.
   task automatic issue(input logic [3:0] o, input logic as, input logic [1:0] bs,
                        input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      op = o; a_sel = as; b_sel = bs; a_in = a; b_in = b; op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_div();
      n_busy = 0;
      n_rdy_lo = 0;
      while (busy && n_busy < 100) begin
         if (n_busy == 10) op_valid = 1'b0;
         if (!op_ready) n_rdy_lo++;
         n_busy++;
         @(posedge clk);
         #1;
      end
      op_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_acc", acc_val, 0);
      check("rst_flags", {op_ready, busy, err, done, zero, carry}, 6'b100010);
      @(negedge clk) reset = 1'b1;

      // 1: ADD and acc feedback
      issue(4'd0, 1'b0, 2'd1, 16'd5, 16'd6);
      check("add_5_6", acc_val, 32'd11);
      check("add_done_zero", {done, zero}, 2'b10);
      issue(4'd0, 1'b0, 2'd2, 16'd42, 16'd0);
      check("add_fb", acc_val, 32'd53);

      // 2: SUB, error entry, discard, CLEAR recovery
      issue(4'd1, 1'b0, 2'd2, 16'd823, 16'd0);
      check("sub_fb", acc_val, 32'd770);
      issue(4'd1, 1'b0, 2'd2, 16'd12, 16'd0);
      check("sub_err", {err, done, op_ready}, 3'b101);
      check("sub_err_acc", acc_val, 32'd770);
      issue(4'd0, 1'b0, 2'd1, 16'd1, 16'd1);
      check("err_discard", {acc_val, err, done}, {32'd770, 2'b10});
      issue(4'd14, 1'b0, 2'd0, 16'd0, 16'd0);
      check("err_clear", {acc_val, err, zero, done}, {32'd0, 3'b011});

      // 3: divides, with an op held on op_valid while busy
      issue(4'd3, 1'b0, 2'd1, 16'd2048, 16'd16);
      op = 4'd3; a_in = 16'd9999; b_in = 16'd3; op_valid = 1'b1;
      wait_div();
      check("div_busy_cycles", n_busy, 16);
      check("div_rdy_lo_cycles", n_rdy_lo, 16);
      check("div_2048_16", {acc_val, done, op_ready}, {32'h0000_0080, 2'b11});
      @(posedge clk);
      #1;
      check("div_held_ignored", {acc_val, busy, done}, {32'h0000_0080, 2'b00});
      issue(4'd3, 1'b0, 2'd1, 16'd100, 16'd7);
      wait_div();
      check("div_100_7", {acc_val, done}, {32'h0002_000E, 1'b1});

      // 4: divide by zero
      issue(4'd3, 1'b0, 2'd1, 16'd5, 16'd0);
      check("div0_flags", {err, op_ready, busy, done}, 4'b1100);
      @(posedge clk);
      #1;
      check("div0_hold", {acc_val, busy, err}, {32'h0002_000E, 2'b01});
      issue(4'd14, 1'b0, 2'd0, 16'd0, 16'd0);
      check("div0_clear", {acc_val, err}, {32'd0, 1'b0});

      // 5: width edges and operand sources
      issue(4'd2, 1'b0, 2'd1, 16'hFFFF, 16'hFFFF);
      check("mul_max", acc_val, 32'hFFFE_0001);
      issue(4'd0, 1'b0, 2'd1, 16'hFFFF, 16'h0001);
      check("add_carry", {acc_val, carry}, {32'h0001_0000, 1'b1});
      issue(4'd11, 1'b0, 2'd1, 16'd20, 16'd1);
      check("shl_20", {acc_val, carry}, {32'h0010_0000, 1'b0});
      issue(4'd11, 1'b0, 2'd1, 16'd40, 16'd1);
      check("shl_40", {acc_val, zero}, {32'd0, 1'b1});
      issue(4'd7, 1'b0, 2'd1, 16'd0, 16'h00F0);
      check("not_f0", acc_val, 32'h0000_FF0F);
      issue(4'd0, 1'b0, 2'd3, 16'd1, 16'hAAAA);
      check("add_bsel3", acc_val, 32'h0000_00F1);
      issue(4'd12, 1'b0, 2'd1, 16'd15, 16'h8000);
      check("shr_15", acc_val, 32'd1);
      issue(4'd10, 1'b1, 2'd0, 16'd0, 16'd0);
      check("xnor_acc_zero", acc_val, 32'h0000_FFFE);
      issue(4'd13, 1'b0, 2'd0, 16'd0, 16'd0);
      check("nop", {acc_val, done}, {32'h0000_FFFE, 1'b1});

      // 6: reset in the middle of a divide
      issue(4'd3, 1'b0, 2'd1, 16'd2048, 16'd16);
      repeat (5) @(posedge clk);
      #1;
      check("mid_div_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("mid_div_reset", {acc_val, op_ready, busy, err, done, zero, carry},
            {32'd0, 6'b100010});
      @(negedge clk) reset = 1'b1;
      issue(4'd0, 1'b0, 2'd1, 16'd1, 16'd1);
      check("post_reset_add", {acc_val, done, busy}, {32'd2, 2'b10});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit accumulator ALU.
- Keeps the 15-op encoding and the Ready/Error state behaviour.
- Adds:
  - generic operand width;
  - a valid/ready operand handshake;
  - a multi-cycle restoring divider that returns both quotient and remainder;
  - registered status flags.
- Sits between the operand/register front end and the result bus; acc_val feeds back as an operand source.

Parameters:
- WIDTH, 16, operand width; the accumulator is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 NAND, 9 NOR, 10 XNOR, 11 SHL, 12 SHR, 13 NOP, 14 CLEAR, 15 illegal.
- a_sel  in  1  A source: 0 a_in, 1 acc_val[WIDTH-1:0].
- b_sel  in  2  B source: 0 zero, 1 b_in, 2 acc_val[WIDTH-1:0], 3 previously latched B.
- a_in  in  WIDTH  external operand A.
- b_in  in  WIDTH  external operand B.
- acc_val  out  2*WIDTH  accumulator.
- done  out  1  one-cycle pulse when acc_val has been updated by a completed op.
- busy  out  1  divider running.
- err  out  1  Error state.
- zero  out  1  acc_val == 0.
- carry  out  1  bit WIDTH of the last ADD result; cleared by any other completed op.

Behaviour:
- **Reset (reset low, asynchronous):**
  - acc_val=0, latched A/B=0, state READY.
  - op_ready=1, busy=0, err=0, done=0, zero=1, carry=0.
- **States:** READY, BUSY, ERROR.
- **Accept:** an op is accepted on a rising edge with op_valid && op_ready.
  - A and B are captured at that edge from a_sel/b_sel.
  - The b_sel=3 register updates on every accept.
- **op_ready:** 1 in READY and ERROR, 0 in BUSY.
- **Single-cycle ops (READY; all except DIV with B≠0):**
  - acc_val, flags written on the accept edge.
  - done=1 for the following cycle.
  - Back-to-back accepts allowed every cycle.
- **Arithmetic and width rules (results zero-extended to 2*WIDTH unless noted):**
  - ADD: A+B, including carry into bit WIDTH.
  - SUB: A−B.
  - MUL: full 2*WIDTH product.
  - AND/OR/XOR/NAND/NOR/XNOR/NOT: computed at WIDTH bits, then zero-extended. NOT operates on B.
  - SHL: B<<A. SHR: B>>A. Computed at 2*WIDTH; shift amount A ≥ 2*WIDTH yields 0.
  - NOP: acc_val unchanged, done pulses.
  - CLEAR: acc_val=0.
- **Errors (checked at the accept edge):**
  - SUB with B>A, DIV with B=0, and op=15 all go to ERROR.
  - acc_val is unchanged, err=1 from the next cycle, no done.
- **ERROR state:**
  - Every op other than CLEAR is accepted and discarded: no done, acc_val and flags unchanged.
  - CLEAR: acc_val=0, err=0, done pulses, go to READY.
- **CLEAR in READY:** acc_val=0, done pulses.
- **DIV with B≠0 (edge t0 = accept):**
  - Go to BUSY; busy=1 and op_ready=0 from t0.
  - Restoring divider, one quotient bit per edge t1..tWIDTH.
  - At tWIDTH: acc_val={remainder, quotient}; return to READY; op_ready=1 and done=1 in the following cycle.
  - Latency is WIDTH cycles.
  - op_valid during BUSY is ignored, not queued.
- **Reset mid-divide:** aborts immediately to reset values; the partial result is discarded.
- **Flag timing:** zero and carry are registered together with acc_val and are never updated by discarded ops.

Test Plan:
1. WIDTH=16; reset; ADD a_in=5, b_sel=1 b_in=6 → next cycle acc_val=11, done=1, zero=0. Then ADD a_in=42, b_sel=2 → 53.
2. SUB a_in=823, b_sel=2 → 770. Then SUB a_in=12, b_sel=2 → err=1, acc_val stays 770, no done. Then ADD → discarded. Then CLEAR → acc_val=0, err=0, zero=1, done=1.
3. DIV 2048/16 → busy=1 and op_ready=0 for exactly 16 cycles, then acc_val=0x00000080, done=1. DIV 100/7 → 0x0002000E. A DIV held on op_valid while busy must not be executed.
4. DIV a_in=5, b_in=0 → err=1 next cycle, op_ready stays 1, busy never asserts, acc_val unchanged.
5. Width checks:
   - MUL 0xFFFF×0xFFFF → 0xFFFE0001.
   - ADD 0xFFFF+1 → 0x00010000, carry=1.
   - SHL a_in=20, b_in=1 → 0x00100000.
   - SHL a_in=40 → 0.
   - NOT b_in=0x00F0 → 0x0000FF0F.
6. Assert reset low at t5 of a DIV → all outputs return to reset values immediately. After release, ADD 1+1 → 2.
